seq_pattern_gen: RTL and testbench



---
 rtl/seq_pkg.sv | 27 ++
 rtl/seq_piso_shreg.sv | 43 ++++
 rtl/seq_pattern_gen.sv | 157 +++++++++++++++
 tb/tb_seq_pattern_gen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern generator
// and the sequence-detector benches that consume its stream.
// Optional feature macro: SEQ_GAP_EN (adds the inter-repetition GAP state).
package seq_pkg;

    localparam int SEQ_PAT_W = 4;
    localparam int SEQ_CNT_W = 8;

    // Default pattern, also used by the detector benches.
    localparam logic [3:0] SEQ_DEF_PAT = 4'b1010;

`ifdef SEQ_GAP_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        FIN   = 2'd3
    } seq_state_e;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd3
    } seq_state_e;
`endif

endpackage

// File: rtl/seq_piso_shreg.sv
// Parallel-load, MSB-first shift register holding the pattern and a
// bit index. Ports: clk_i, reset_i (sync, active-high), load_i (latch
// data_i, index to MSB), adv_i (step index, wraps at 0), data_i,
// nxt_bit_o (bit selected after the next step), last_o (index is 0).
module seq_piso_shreg
    import seq_pkg::*;
#(
    parameter int PAT_W = SEQ_PAT_W
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic             adv_i,
    input  logic [PAT_W-1:0] data_i,
    output logic             nxt_bit_o,
    output logic             last_o
);

    localparam int IW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IW-1:0] TOP = IW'(PAT_W - 1);

    logic [PAT_W-1:0] pat_q;
    logic [IW-1:0]    idx_q;
    logic [IW-1:0]    nxt_idx;

    assign last_o    = (idx_q == '0);
    // Wrapping here gives the back-to-back stream between repetitions.
    assign nxt_idx   = last_o ? TOP : idx_q - IW'(1);
    assign nxt_bit_o = pat_q[nxt_idx];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pat_q <= '0;
            idx_q <= '0;
        end else if (load_i) begin
            pat_q <= data_i;
            idx_q <= TOP;
        end else if (adv_i) begin
            idx_q <= nxt_idx;
        end
    end

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends pattern_in MSB-first repeat_cnt times.
// Ports: clk, reset (sync, active-high), start, pattern_in, repeat_cnt
// in; dout, dout_valid, busy, done (one-cycle pulse) out, all registered.
// Macro SEQ_GAP_EN inserts GAP_LEN idle cycles between repetitions.
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int PAT_W   = SEQ_PAT_W,
    parameter int CNT_W   = SEQ_CNT_W,
    parameter int GAP_LEN = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic [CNT_W-1:0] repeat_cnt,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    if (PAT_W < 2 || CNT_W < 1 || GAP_LEN < 1) begin : g_bad_cfg
        $error("seq_pattern_gen: unsupported parameter set");
    end

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic             dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ld, adv, nxt_bit, last;

`ifdef SEQ_GAP_EN
    localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    logic [GW-1:0] gap_q, gap_d;
`endif

    seq_piso_shreg #(.PAT_W(PAT_W)) u_shreg (
        .clk_i     (clk),
        .reset_i   (reset),
        .load_i    (ld),
        .adv_i     (adv),
        .data_i    (pattern_in),
        .nxt_bit_o (nxt_bit),
        .last_o    (last)
    );

    always_comb begin
        state_d = state_q;
        rep_d   = rep_q;
        dout_d  = 1'b0;
        valid_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ld      = 1'b0;
        adv     = 1'b0;
`ifdef SEQ_GAP_EN
        gap_d   = gap_q;
`endif
        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    busy_d = 1'b1;
                    if (repeat_cnt != '0) begin
                        ld      = 1'b1;
                        rep_d   = repeat_cnt;
                        dout_d  = pattern_in[PAT_W-1];
                        valid_d = 1'b1;
                        state_d = SHIFT;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            SHIFT: begin
                if (!last) begin
                    adv     = 1'b1;
                    dout_d  = nxt_bit;
                    valid_d = 1'b1;
                end else begin
                    rep_d = rep_q - CNT_W'(1);
                    if (rep_q == CNT_W'(1)) begin
                        state_d = FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
`ifdef SEQ_GAP_EN
                        // Index stays at 0 so leaving GAP wraps to MSB.
                        state_d = GAP;
                        gap_d   = GW'(GAP_LEN - 1);
`else
                        adv     = 1'b1;
                        dout_d  = nxt_bit;
                        valid_d = 1'b1;
`endif
                    end
                end
            end
`ifdef SEQ_GAP_EN
            GAP: begin
                if (gap_q == '0) begin
                    state_d = SHIFT;
                    adv     = 1'b1;
                    dout_d  = nxt_bit;
                    valid_d = 1'b1;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
`endif
            FIN: begin
                // Empty runs reach FIN with busy still high; the
                // done pulse is emitted here before returning to IDLE.
                busy_d = 1'b0;
                if (done_q) begin
                    state_d = IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rep_q   <= '0;
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SEQ_GAP_EN
            gap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            rep_q   <= rep_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SEQ_GAP_EN
            gap_q   <= gap_d;
`endif
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen: a queue-based stream model
// checked every cycle, plus directed runs with literal expectations.
module tb_seq_pattern_gen;

    localparam int PAT_W   = 4;
    localparam int CNT_W   = 8;
    localparam int GAP_LEN = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [PAT_W-1:0] pattern_in;
    logic [CNT_W-1:0] repeat_cnt;
    logic             dout, dout_valid, busy, done;

    int vectors     = 0;
    int miscompares = 0;
    logic chk_en    = 1'b0;

    // Expected outputs per cycle, packed as {dout, valid, busy, done}.
    logic [3:0] q[$];
    logic [3:0] cur = 4'b0000;

    always #5 clk = ~clk;

    seq_pattern_gen #(
        .PAT_W   (PAT_W),
        .CNT_W   (CNT_W),
        .GAP_LEN (GAP_LEN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pattern_in (pattern_in),
        .repeat_cnt (repeat_cnt),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .done       (done)
    );

    task automatic build(input logic [PAT_W-1:0] p, input int cnt);
        for (int r = 0; r < cnt; r++) begin
            for (int b = PAT_W - 1; b >= 0; b--)
                q.push_back({p[b], 3'b110});
`ifdef SEQ_GAP_EN
            if (r < cnt - 1)
                for (int g = 0; g < GAP_LEN; g++)
                    q.push_back(4'b0010);
`endif
        end
        if (cnt == 0)
            q.push_back(4'b0010);
        q.push_back(4'b0001);
    endtask

    // Model: a run is accepted only when fully idle (nothing pending,
    // not busy, not on the done cycle); the stream starts next cycle.
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            cur = 4'b0000;
        end else begin
            if (start && q.size() == 0 && cur == 4'b0000)
                build(pattern_in, int'(repeat_cnt));
            cur = (q.size() > 0) ? q.pop_front() : 4'b0000;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if ({dout, dout_valid, busy, done} !== cur) begin
                miscompares++;
                $display("FAIL cycle_cmp t=%0t dut=%b exp=%b",
                         $time, {dout, dout_valid, busy, done}, cur);
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic run(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] cnt,
                       input int maxc, input int mid_c, input int rst_c,
                       input int exp_q, output logic [63:0] bits,
                       output int nbits, output int busyc,
                       output int done_at, output int ndone);
        bits = '0; nbits = 0; busyc = 0; done_at = 0; ndone = 0;
        pattern_in = pat;
        repeat_cnt = cnt;
        start = 1'b1;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 1 && exp_q >= 0)
                check("model_qlen", 64'(q.size()), 64'(exp_q));
            if (c == rst_c + 1) begin
                check("rst_outs", 64'({dout, dout_valid, busy, done}), 64'd0);
                reset = 1'b0;
            end
            if (dout_valid) begin
                bits = {bits[62:0], dout};
                nbits++;
            end
            if (busy) busyc++;
            if (done) begin
                ndone++;
                if (done_at == 0) done_at = c;
            end
            if (c == mid_c) begin
                start = 1'b1;
                pattern_in = 4'b1111;
            end
            if (c == rst_c) reset = 1'b1;
        end
    endtask

    logic [63:0] bits;
    int nbits, busyc, done_at, ndone;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        pattern_in = '0;
        repeat_cnt = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        check("reset_outs", 64'({dout, dout_valid, busy, done}), 64'd0);
        @(negedge clk);

        // 1010 x3
        run(4'b1010, 8'd3, 20, -1, -1, 12, bits, nbits, busyc, done_at, ndone);
        check("x3_bits", bits[11:0], 64'hAAA);
        check("x3_nbits", 64'(nbits), 64'd12);
        check("x3_done_at", 64'(done_at), 64'd13);
        check("x3_ndone", 64'(ndone), 64'd1);
        check("x3_busy", 64'(busyc), 64'd12);

        // empty run
        run(4'b1010, 8'd0, 10, -1, -1, 1, bits, nbits, busyc, done_at, ndone);
        check("z_nbits", 64'(nbits), 64'd0);
        check("z_busy", 64'(busyc), 64'd1);
        check("z_done_at", 64'(done_at), 64'd2);
        check("z_ndone", 64'(ndone), 64'd1);

        // restart and pattern change mid-run are ignored
        run(4'b1010, 8'd2, 20, 3, -1, -1, bits, nbits, busyc, done_at, ndone);
        check("mid_bits", bits[7:0], 64'hAA);
        check("mid_nbits", 64'(nbits), 64'd8);
        check("mid_done_at", 64'(done_at), 64'd9);
        check("mid_ndone", 64'(ndone), 64'd1);

        // reset after the 5th bit aborts the run
        run(4'b1010, 8'd3, 20, -1, 5, -1, bits, nbits, busyc, done_at, ndone);
        check("abort_bits", bits[4:0], 64'h15);
        check("abort_nbits", 64'(nbits), 64'd5);
        check("abort_ndone", 64'(ndone), 64'd0);
        run(4'b1010, 8'd1, 10, -1, -1, 4, bits, nbits, busyc, done_at, ndone);
        check("clean_bits", bits[3:0], 64'hA);
        check("clean_done_at", 64'(done_at), 64'd5);

        // two repetitions of 1011, with or without the gap
        run(4'b1011, 8'd2, 20, -1, -1, -1, bits, nbits, busyc, done_at, ndone);
        check("g_bits", bits[7:0], 64'hBB);
        check("g_nbits", 64'(nbits), 64'd8);
`ifdef SEQ_GAP_EN
        check("g_busy", 64'(busyc), 64'd10);
        check("g_done_at", 64'(done_at), 64'd11);
`else
        check("g_busy", 64'(busyc), 64'd8);
        check("g_done_at", 64'(done_at), 64'd9);
`endif

        // maximum repeat count
        run(4'b1001, 8'd255, 1030, -1, -1, -1, bits, nbits, busyc, done_at, ndone);
        check("max_tail", bits[7:0], 64'h99);
        check("max_nbits", 64'(nbits), 64'd1020);
`ifdef SEQ_GAP_EN
        check("max_done_at", 64'(done_at), 64'(1021 + 254 * GAP_LEN));
`else
        check("max_done_at", 64'(done_at), 64'd1021);
`endif
        check("max_ndone", 64'(ndone), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
